// File: rtl/maxpool.sv
// maxpool: pooling stage after conv/ReLU, one registered output pixel per clock.
// Max pooling by default; define POOL_AVG_EN for floor-average pooling.
module maxpool #(
    parameter int DATA_WIDTH  = 8,
    parameter int IN_SIZE     = 4,
    parameter int POOL_SIZE   = 2,
    parameter int POOL_STRIDE = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] pool_ifmap [IN_SIZE][IN_SIZE],
    output logic [DATA_WIDTH-1:0] pool_ofmap [(IN_SIZE-POOL_SIZE)/POOL_STRIDE+1]
                                             [(IN_SIZE-POOL_SIZE)/POOL_STRIDE+1],
    output logic                  pool_done
);

    localparam int OUT_SIZE = (IN_SIZE - POOL_SIZE) / POOL_STRIDE + 1;
    localparam int CW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
    localparam int IW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam logic [CW-1:0] LAST = CW'(OUT_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE,
        PROCESS,
        DONE
    } state_t;

    state_t state;
    state_t next;

    logic [CW-1:0]         row;
    logic [CW-1:0]         col;
    logic                  wr;
    logic                  clr;
    logic                  last;
    logic [DATA_WIDTH-1:0] win_val;

    assign last      = (row == LAST) && (col == LAST);
    assign pool_done = (state == DONE);

`ifdef POOL_AVG_EN
    localparam int SH = 2 * $clog2(POOL_SIZE);
    localparam int SW = DATA_WIDTH + SH;

    logic [SW-1:0] sum;

    // Power-of-two window, so the floor average is a plain shift.
    always_comb begin
        sum = '0;
        for (int i = 0; i < POOL_SIZE; i++) begin
            for (int j = 0; j < POOL_SIZE; j++) begin
                sum = sum + SW'(pool_ifmap
                    [IW'(int'(row) * POOL_STRIDE + i)]
                    [IW'(int'(col) * POOL_STRIDE + j)]);
            end
        end
        win_val = DATA_WIDTH'(sum >> SH);
    end
`else
    logic [DATA_WIDTH-1:0] pix;

    always_comb begin
        win_val = '0;
        pix     = '0;
        for (int i = 0; i < POOL_SIZE; i++) begin
            for (int j = 0; j < POOL_SIZE; j++) begin
                pix = pool_ifmap
                    [IW'(int'(row) * POOL_STRIDE + i)]
                    [IW'(int'(col) * POOL_STRIDE + j)];
                if (pix > win_val) begin
                    win_val = pix;
                end
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        wr   = 1'b0;
        clr  = 1'b0;
        unique case (state)
            IDLE: begin
                if (en) begin
                    next = PROCESS;
                end
            end
            PROCESS: begin
                // en low pauses the scan in place.
                if (en) begin
                    wr = 1'b1;
                    if (last) begin
                        next = DONE;
                    end
                end
            end
            DONE: begin
                if (!en) begin
                    next = IDLE;
                    clr  = 1'b1;
                end
            end
            default: begin
                next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (wr) begin
            if (col == LAST) begin
                col <= '0;
                row <= last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < OUT_SIZE; r++) begin
                for (int c = 0; c < OUT_SIZE; c++) begin
                    pool_ofmap[r][c] <= '0;
                end
            end
        end else if (wr) begin
            pool_ofmap[row][col] <= win_val;
        end
    end

endmodule
